// File: rtl/uart_tx_framer_pkg.sv
// uart_tx_framer_pkg: shared UART constants for the transmit framer and receive checker.
package uart_tx_framer_pkg;
    typedef logic [2:0] state_t;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_calc.sv
// parity_calc: parity bit for a payload, even or odd as selected by typ_i.
module parity_calc
    import uart_tx_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  typ_i,
    output logic                  par_o
);
    assign par_o = (^data_i) ^ (typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises a latched payload as START, LSB-first data, optional parity, STOP.
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int   DATA_WIDTH     = 8,
    parameter logic STOP_BIT_VALUE = 1'b1,
    parameter logic IDLE_LEVEL     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    pen_q, pen_d, ptyp_q, ptyp_d;
    logic                    tx_q, tx_d, busy_q, par;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data_i(data_q),
        .typ_i (ptyp_q),
        .par_o (par)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        case (state_q)
            S_IDLE: if (DATA_VALID) begin
                state_d = S_START;
                data_d  = P_DATA;
                pen_d   = PAR_EN;
                ptyp_d  = PAR_TYP;
            end
            S_START: state_d = S_DATA;
            S_DATA: if (cnt_q == LAST) begin
                state_d = pen_q ? S_PARITY : S_STOP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_PARITY: state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
        // TX_OUT is registered, so it is decoded from the state being entered
        tx_d = state_d == S_START  ? 1'b0 :
               state_d == S_DATA   ? data_d[cnt_d] :
               state_d == S_PARITY ? par :
               state_d == S_STOP   ? STOP_BIT_VALUE : IDLE_LEVEL;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            tx_q    <= tx_d;
            busy_q  <= state_d != S_IDLE;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed and random frames checked against a bit-list reference model.
module tb_uart_tx_framer;
    import uart_tx_framer_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT, BUSY;
    int         n_assert = 0;
    int         n_fail = 0;

    uart_tx_framer dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp, input logic hold);
        @(posedge CLK); #1;
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = hold;
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    endtask

    // Expected line: start 0, payload LSB first, parity making the ones-count even/odd, stop 1
    task automatic check_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                               input int pulse_idx, input string tag);
        logic q[$];
        int   ones;
        ones = $countones(d);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pen) q.push_back(ptyp == PAR_EVEN ? ones[0] : ~ones[0]);
        q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            chk($sformatf("%s tx bit%0d", tag, i), TX_OUT, q[i]);
            chk($sformatf("%s busy bit%0d", tag, i), BUSY, 1'b1);
            if (i == pulse_idx) DATA_VALID = 1'b1;
            else if (pulse_idx >= 0 && i == pulse_idx + 1) DATA_VALID = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge CLK);
        chk({tag, " idle tx"}, TX_OUT, 1'b1);
        chk({tag, " idle busy"}, BUSY, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       pen, ptyp;
        #3 RST = 1'b0;
        #1;
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", BUSY, 1'b0);
        @(negedge CLK); RST = 1'b1;
        check_idle("post_reset");

        start_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, -1, "a5_nopar");
        check_idle("a5_nopar");

        start_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0);
        check_frame(8'hA5, 1'b1, PAR_EVEN, -1, "a5_even");
        check_idle("a5_even");

        start_frame(8'hA5, 1'b1, PAR_ODD, 1'b0);
        check_frame(8'hA5, 1'b1, PAR_ODD, -1, "a5_odd");
        check_idle("a5_odd");

        start_frame(8'h00, 1'b1, PAR_ODD, 1'b0);
        check_frame(8'h00, 1'b1, PAR_ODD, -1, "zero_odd");
        check_idle("zero_odd");

        @(posedge CLK); #1;
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        P_DATA = 8'hC3;
        check_frame(8'h3C, 1'b0, 1'b0, -1, "cont_first");
        check_idle("cont_gap");
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        check_frame(8'hC3, 1'b0, 1'b0, -1, "cont_second");
        check_idle("cont_second");

        start_frame(8'h5A, 1'b1, PAR_ODD, 1'b0);
        check_frame(8'h5A, 1'b1, PAR_ODD, 9, "par_pulse");
        repeat (3) check_idle("par_pulse");

        start_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midreset tx", TX_OUT, 1'b1);
        chk("midreset busy", BUSY, 1'b0);
        @(negedge CLK); RST = 1'b1;
        check_idle("midreset");
        start_frame(8'h96, 1'b1, PAR_EVEN, 1'b0);
        check_frame(8'h96, 1'b1, PAR_EVEN, -1, "after_reset");
        check_idle("after_reset");

        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
            start_frame(d, pen, ptyp, 1'b0);
            check_frame(d, pen, ptyp, -1, $sformatf("rand%0d", k));
            check_idle($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter STOP_BIT_VALUE, default 1, meaning line level driven during the stop bit.
REQ-003 SHALL have parameter IDLE_LEVEL, default 1, meaning line level driven while idle and after reset.
REQ-004 SHALL have port CLK  input  1  bit-rate clock, one serial bit per rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-007 SHALL have port DATA_VALID  input  1  payload-present strobe.
REQ-008 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-009 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-010 SHALL have port TX_OUT  output  1  registered serial line.
REQ-011 SHALL have port BUSY  output  1  high while a frame is on the line.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a frame only in IDLE with DATA_VALID=1, latching P_DATA, PAR_EN and PAR_TYP on that edge.
REQ-014 SHALL ignore DATA_VALID in every state other than IDLE; no queuing, no error flag.
REQ-015 SHALL drive TX_OUT=0 for exactly one cycle in START, beginning the cycle after acceptance.
REQ-016 SHALL shift DATA_WIDTH bits LSB-first in DATA, one per cycle, using a bit counter 0..DATA_WIDTH-1 that clears on leaving DATA.
REQ-017 SHALL enter PARITY after the last data bit only if latched PAR_EN=1, else go directly to STOP.
REQ-018 SHALL drive parity = XOR of latched payload for even, inverted for odd, for one cycle.
REQ-019 SHALL drive TX_OUT=STOP_BIT_VALUE for one cycle in STOP, then return to IDLE.
REQ-020 SHALL drive TX_OUT=IDLE_LEVEL in IDLE.
REQ-021 SHALL assert BUSY from the START cycle through the STOP cycle inclusive, low in IDLE.
REQ-022 SHALL produce frame length 2+DATA_WIDTH+latched PAR_EN cycles, minimum one IDLE cycle between frames.
REQ-023 SHALL ignore changes on P_DATA, PAR_EN and PAR_TYP during a frame.
REQ-024 SHALL resolve an X-free TX_OUT every cycle after reset; no combinational path from inputs to TX_OUT or BUSY.

Reset
REQ-025 SHALL on RST=0 immediately force state IDLE, TX_OUT=IDLE_LEVEL, BUSY=0, counter and payload register 0.
REQ-026 SHALL abort any frame in progress on reset mid-frame, with no partial stop bit; the next accepted frame starts cleanly with START.

Structure
REQ-027 SHALL place FSM state encoding and parity-type constants (EVEN=0, ODD=1) in the shared UART package used by the receiver side.
REQ-028 SHALL instantiate one sub-module parity_calc (payload + type -> parity bit), the counterpart of the receive-side checker; serializer and FSM stay in uart_tx_framer.

Verification
REQ-029 SHALL cover: 0xA5, PAR_EN=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 then idle 1; BUSY high 10 cycles.
REQ-030 SHALL cover: 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame; PAR_TYP=1 -> parity bit 1.
REQ-031 SHALL cover: 0x00, odd parity -> 8 zero data bits, parity 1, stop 1.
REQ-032 SHALL cover: DATA_VALID held high continuously with 0x3C then 0xC3 -> two complete frames separated by exactly one IDLE cycle; mid-frame P_DATA change has no effect.
REQ-033 SHALL cover: RST pulsed low during DATA bit 3 -> TX_OUT=1, BUSY=0 immediately; next DATA_VALID produces a full correct frame.
REQ-034 SHALL cover: DATA_VALID pulsed during PARITY cycle -> ignored, no second frame.
